// File: rtl/axi4l_mem_bridge_if.sv
// AXI4-Lite channel bundle between a master and the memory bridge.
// The master modport drives requests; the slave modport returns readys and responses.
interface axi4l_mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                      aw_valid;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic                      aw_ready;
  logic                      w_valid;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      w_ready;
  logic                      b_valid;
  logic [1:0]                b_resp;
  logic                      b_ready;
  logic                      ar_valid;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic                      ar_ready;
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;
  logic                      r_ready;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi4l_mem_bridge.sv
// AXI4-Lite slave terminating one transaction at a time onto a single-port SRAM.
// Read/write arbitration alternates when both are pending; out-of-window accesses get DECERR.
module axi4l_mem_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MEM_SIZE_BYTES = 4096,
  parameter int                    MEM_RD_LATENCY = 1,
  localparam int                   MEM_ADDR_WIDTH = $clog2(MEM_SIZE_BYTES / (DATA_WIDTH / 8))
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  axi4l_mem_bridge_if.slave         axi,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_strb_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic                      mem_err_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(STRB_W);
  localparam int OFF_W  = $clog2(MEM_SIZE_BYTES);
  localparam int CNT_W  = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LATENCY - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RESP_B,
    S_RESP_R
  } state_e;

  typedef enum logic {
    GRANT_WRITE,
    GRANT_READ
  } grant_e;

  // The window is aligned to its size, so a tag compare replaces the two-sided range check.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFF_W) == (BASE_ADDR >> OFF_W);
  endfunction

  function automatic logic [MEM_ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return MEM_ADDR_WIDTH'(off >> BYTE_W);
  endfunction

  state_e                    state_q, state_d;
  grant_e                    last_grant_q, last_grant_d;
  logic                      is_write_q, is_write_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]         strb_q, strb_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                b_resp_q, b_resp_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0]     r_data_q, r_data_d;

  logic wr_pend;
  logic rd_pend;
  logic grant_wr;
  logic grant_rd;

  assign wr_pend = axi.aw_valid & axi.w_valid;
  assign rd_pend = axi.ar_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    cnt_d        = cnt_q;
    b_resp_d     = b_resp_q;
    r_resp_d     = r_resp_q;
    r_data_d     = r_data_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Readys are held off during reset so nothing is accepted into a flushed FSM.
        if (!rst_i) begin
          if (wr_pend && (!rd_pend || last_grant_q == GRANT_READ)) begin
            grant_wr = 1'b1;
          end else if (rd_pend) begin
            grant_rd = 1'b1;
          end
        end

        if (grant_wr) begin
          last_grant_d = GRANT_WRITE;
          is_write_d   = 1'b1;
          wdata_d      = axi.w_data;
          strb_d       = axi.w_strb;
          if (in_window(axi.aw_addr)) begin
            addr_d  = word_index(axi.aw_addr);
            state_d = S_MEM_REQ;
          end else begin
            b_resp_d = RESP_DECERR;
            state_d  = S_RESP_B;
          end
        end else if (grant_rd) begin
          last_grant_d = GRANT_READ;
          is_write_d   = 1'b0;
          strb_d       = '1;
          if (in_window(axi.ar_addr)) begin
            addr_d  = word_index(axi.ar_addr);
            state_d = S_MEM_REQ;
          end else begin
            r_data_d = '0;
            r_resp_d = RESP_DECERR;
            state_d  = S_RESP_R;
          end
        end
      end

      S_MEM_REQ: begin
        cnt_d   = '0;
        state_d = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (is_write_q) begin
            b_resp_d = mem_err_i ? RESP_SLVERR : RESP_OKAY;
            state_d  = S_RESP_B;
          end else begin
            r_data_d = mem_rdata_i;
            r_resp_d = mem_err_i ? RESP_SLVERR : RESP_OKAY;
            state_d  = S_RESP_R;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP_B: begin
        if (axi.b_ready) begin
          state_d = S_IDLE;
        end
      end

      S_RESP_R: begin
        if (axi.r_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_READ;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      cnt_q        <= '0;
      b_resp_q     <= '0;
      r_resp_q     <= '0;
      r_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      cnt_q        <= cnt_d;
      b_resp_q     <= b_resp_d;
      r_resp_q     <= r_resp_d;
      r_data_q     <= r_data_d;
    end
  end

  assign axi.aw_ready = grant_wr;
  assign axi.w_ready  = grant_wr;
  assign axi.ar_ready = grant_rd;
  assign axi.b_valid  = (state_q == S_RESP_B);
  assign axi.b_resp   = b_resp_q;
  assign axi.r_valid  = (state_q == S_RESP_R);
  assign axi.r_data   = r_data_q;
  assign axi.r_resp   = r_resp_q;

  assign mem_req_o   = (state_q == S_MEM_REQ);
  assign mem_we_o    = mem_req_o & is_write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_strb_o  = strb_q;

endmodule

// File: tb/tb_axi4l_mem_bridge.sv
// Directed bench for axi4l_mem_bridge: vector table of single transactions plus
// hand-written sequences for arbitration, response back-pressure and mid-transaction reset.
module tb_axi4l_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_strb;
  logic [63:0] mem_rdata = '0;
  logic        mem_err   = 1'b0;
  logic        err_inj   = 1'b0;
  logic [63:0] mem [512];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi4l_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

  axi4l_mem_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BASE_ADDR(32'h0),
    .MEM_SIZE_BYTES(4096), .MEM_RD_LATENCY(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi(axi),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One-cycle-latency SRAM: read data and error are valid the cycle after the request.
  always @(posedge clk) begin
    mem_err <= mem_req & err_inj;
    if (mem_req) begin
      if (mem_we) mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_strb);
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    axi.aw_valid = 0; axi.aw_addr = '0; axi.w_valid = 0; axi.w_data = '0; axi.w_strb = '0;
    axi.b_ready = 0; axi.ar_valid = 0; axi.ar_addr = '0; axi.r_ready = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        err;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic        memreq;
    logic [8:0]  madr;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic run_txn(input vec_t v, input string tag);
    int   t;
    int   resp_cyc;
    int   req_cyc;
    logic seen_req;
    logic [8:0] req_adr;
    logic req_we;
    logic hs;
    @(negedge clk);
    err_inj = v.err;
    if (v.wr) begin
      axi.aw_valid = 1; axi.aw_addr = v.addr; axi.w_valid = 1; axi.w_data = v.data; axi.w_strb = v.strb;
    end else begin
      axi.ar_valid = 1; axi.ar_addr = v.addr;
    end
    #1;
    t = 0;
    hs = v.wr ? (axi.aw_ready & axi.w_ready) : axi.ar_ready;
    while (!hs && t < 20) begin
      @(negedge clk); #1;
      t++;
      hs = v.wr ? (axi.aw_ready & axi.w_ready) : axi.ar_ready;
    end
    check({tag, "_hs_wait"}, 64'(t), 64'd0);
    if (!hs) begin
      idle_bus();
      return;
    end
    @(posedge clk); #1;
    axi.aw_valid = 0; axi.w_valid = 0; axi.ar_valid = 0;
    resp_cyc = -1; req_cyc = -1; seen_req = 0; req_adr = '0; req_we = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_req) begin
        seen_req = 1; req_cyc = k; req_adr = mem_addr; req_we = mem_we;
      end
      if (axi.b_valid || axi.r_valid) begin
        resp_cyc = k;
        break;
      end
    end
    check({tag, "_resp_cycle"}, 64'(resp_cyc), 64'(v.lat));
    check({tag, "_mem_req_seen"}, 64'(seen_req), 64'(v.memreq));
    if (v.memreq) begin
      check({tag, "_mem_req_cycle"}, 64'(req_cyc), 64'd1);
      check({tag, "_mem_addr"}, 64'(req_adr), 64'(v.madr));
      check({tag, "_mem_we"}, 64'(req_we), 64'(v.wr));
    end
    check({tag, "_valid_chan"}, {62'd0, axi.b_valid, axi.r_valid}, v.wr ? 64'd2 : 64'd1);
    if (v.wr) begin
      check({tag, "_bresp"}, 64'(axi.b_resp), 64'(v.resp));
      axi.b_ready = 1;
    end else begin
      check({tag, "_rresp"}, 64'(axi.r_resp), 64'(v.resp));
      check({tag, "_rdata"}, axi.r_data, v.rdata);
      axi.r_ready = 1;
    end
    @(posedge clk); #1;
    axi.b_ready = 0; axi.r_ready = 0;
    err_inj = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   grants[6];
    int   ng;
    int   both;
    int   stray;
    logic [63:0] held;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    vecs[0]  = '{wr:1, addr:32'h10,       data:64'hDEADBEEF_CAFEF00D, strb:8'hFF, err:0, resp:2'b00, rdata:64'h0,                  memreq:1, madr:9'd2,   lat:3};
    vecs[1]  = '{wr:0, addr:32'h10,       data:64'h0,                 strb:8'h00, err:0, resp:2'b00, rdata:64'hDEADBEEF_CAFEF00D, memreq:1, madr:9'd2,   lat:3};
    vecs[2]  = '{wr:1, addr:32'h1000,     data:64'h1111_1111_1111_1111, strb:8'hFF, err:0, resp:2'b11, rdata:64'h0,                memreq:0, madr:9'd0,   lat:1};
    vecs[3]  = '{wr:0, addr:32'h1000,     data:64'h0,                 strb:8'h00, err:0, resp:2'b11, rdata:64'h0,                  memreq:0, madr:9'd0,   lat:1};
    vecs[4]  = '{wr:1, addr:32'hFF8,      data:64'h11223344_55667788, strb:8'hFF, err:0, resp:2'b00, rdata:64'h0,                  memreq:1, madr:9'd511, lat:3};
    vecs[5]  = '{wr:1, addr:32'h13,       data:64'h0,                 strb:8'h0F, err:0, resp:2'b00, rdata:64'h0,                  memreq:1, madr:9'd2,   lat:3};
    vecs[6]  = '{wr:0, addr:32'h17,       data:64'h0,                 strb:8'h00, err:0, resp:2'b00, rdata:64'hDEADBEEF_00000000, memreq:1, madr:9'd2,   lat:3};
    vecs[7]  = '{wr:0, addr:32'hFF8,      data:64'h0,                 strb:8'h00, err:0, resp:2'b00, rdata:64'h11223344_55667788, memreq:1, madr:9'd511, lat:3};
    vecs[8]  = '{wr:1, addr:32'h20,       data:64'h01234567_89ABCDEF, strb:8'hFF, err:1, resp:2'b10, rdata:64'h0,                  memreq:1, madr:9'd4,   lat:3};
    vecs[9]  = '{wr:0, addr:32'hFFFF_FFF0, data:64'h0,                strb:8'h00, err:0, resp:2'b11, rdata:64'h0,                  memreq:0, madr:9'd0,   lat:1};
    vecs[10] = '{wr:0, addr:32'h20,       data:64'h0,                 strb:8'h00, err:1, resp:2'b10, rdata:64'h01234567_89ABCDEF, memreq:1, madr:9'd4,   lat:3};
    vecs[11] = '{wr:0, addr:32'hFF0,      data:64'h0,                 strb:8'h00, err:0, resp:2'b00, rdata:64'h0,                  memreq:1, madr:9'd510, lat:3};

    // Reset: readys must stay low even with every request valid.
    idle_bus();
    rst = 1;
    axi.aw_valid = 1; axi.w_valid = 1; axi.ar_valid = 1; axi.aw_addr = 32'h8; axi.ar_addr = 32'h8;
    repeat (2) @(negedge clk);
    #1;
    check("rst_readys", {61'd0, axi.aw_ready, axi.w_ready, axi.ar_ready}, 64'd0);
    idle_bus();
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_valids", {62'd0, axi.b_valid, axi.r_valid}, 64'd0);
    check("rst_mem_ctl", {62'd0, mem_req, mem_we}, 64'd0);
    check("rst_resps", {60'd0, axi.b_resp, axi.r_resp}, 64'd0);
    check("rst_rdata", axi.r_data, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_strb", 64'(mem_strb), 64'd0);

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both channels pending continuously from reset: grants must alternate W,R,W,R,W,R.
    do_reset();
    axi.aw_valid = 1; axi.aw_addr = 32'h40; axi.w_valid = 1; axi.w_data = 64'h5A5A; axi.w_strb = 8'hFF;
    axi.ar_valid = 1; axi.ar_addr = 32'h40; axi.b_ready = 1; axi.r_ready = 1;
    ng = 0; both = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      #1;
      if (axi.aw_ready && axi.ar_ready) both++;
      if (axi.aw_ready && axi.w_ready) begin grants[ng] = 0; ng++; end
      else if (axi.ar_ready) begin grants[ng] = 1; ng++; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    axi.aw_valid = 0; axi.w_valid = 0; axi.ar_valid = 0;
    repeat (6) @(negedge clk);
    idle_bus();
    check("arb_grant_count", 64'(ng), 64'd6);
    check("arb_both_ready", 64'(both), 64'd0);
    for (int i = 0; i < 6 && i < ng; i++) check($sformatf("arb_grant%0d", i), 64'(grants[i]), 64'(i % 2));

    // Address without data is not a write request; the read wins alone.
    @(negedge clk);
    axi.aw_valid = 1; axi.aw_addr = 32'h10; axi.ar_valid = 1; axi.ar_addr = 32'h40;
    #1;
    check("aw_only_awready", {62'd0, axi.aw_ready, axi.w_ready}, 64'd0);
    check("aw_only_arready", 64'(axi.ar_ready), 64'd1);
    @(posedge clk); #1;
    axi.ar_valid = 0; axi.r_ready = 1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (axi.aw_ready) stray++;
    end
    check("aw_only_never_ready", 64'(stray), 64'd0);
    idle_bus();

    // Read error held under back-pressure with other requests waiting.
    v = '{wr:0, addr:32'h17, data:64'h0, strb:8'h00, err:1, resp:2'b10, rdata:64'h0, memreq:1, madr:9'd2, lat:3};
    @(negedge clk);
    err_inj = 1;
    axi.ar_valid = 1; axi.ar_addr = v.addr;
    #1;
    check("bp_hs", 64'(axi.ar_ready), 64'd1);
    @(posedge clk); #1;
    axi.ar_valid = 0;
    axi.aw_valid = 1; axi.w_valid = 1; axi.aw_addr = 32'h8; axi.w_strb = 8'hFF;
    ng = 0;
    while (!axi.r_valid && ng < 10) begin @(negedge clk); ng++; end
    check("bp_rvalid_cycle", 64'(ng), 64'd3);
    axi.ar_valid = 1; axi.ar_addr = 32'h8;
    held = axi.r_data;
    check("bp_rdata", held, 64'hDEADBEEF_00000000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("bp_hold%0d", c), {59'd0, axi.r_valid, axi.r_resp, axi.aw_ready, axi.ar_ready}, {59'd0, 1'b1, 2'b10, 1'b0, 1'b0});
      check($sformatf("bp_data%0d", c), axi.r_data, 64'hDEADBEEF_00000000);
    end
    idle_bus();
    err_inj = 0;
    axi.r_ready = 1;
    @(posedge clk); #1;
    axi.r_ready = 0;

    // Reset while the memory request is on the bus drops it next cycle.
    @(negedge clk);
    axi.aw_valid = 1; axi.aw_addr = 32'h28; axi.w_valid = 1; axi.w_data = 64'h77; axi.w_strb = 8'hFF;
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check("rst_req_before", 64'(mem_req), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_req_after", 64'(mem_req), 64'd0);

    // Reset during the memory wait: no response ever appears.
    @(negedge clk);
    axi.aw_valid = 1; axi.aw_addr = 32'h30; axi.w_valid = 1; axi.w_data = 64'h99; axi.w_strb = 8'hFF;
    @(posedge clk); #1;
    idle_bus();
    axi.b_ready = 1; axi.r_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    stray = 0;
    repeat (10) begin
      #1;
      if (axi.b_valid || axi.r_valid) stray++;
      @(negedge clk);
    end
    check("rst_wait_no_resp", 64'(stray), 64'd0);
    idle_bus();
    v = '{wr:1, addr:32'h30, data:64'hAA55AA55_0F0F0F0F, strb:8'hFF, err:0, resp:2'b00, rdata:64'h0, memreq:1, madr:9'd6, lat:3};
    run_txn(v, "post_rst_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
